// File: rtl/alu_ex_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shifter, with a held output register.
// Define ALU_SLTU_EN to build the unsigned set-less-than (op 7); otherwise op 7 yields 0.
module alu_ex_stage #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] busOut,
  output logic [4:0]  out_rd,
  output logic        ovf,
  output logic        zero
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] SPC = 5'(SHIFT_PER_CYCLE);

  state_t      state_q, state_d;
  logic [31:0] sh_val_q, sh_val_d;
  logic [4:0]  sh_rem_q, sh_rem_d;
  logic [3:0]  sh_op_q, sh_op_d;
  logic [4:0]  sh_rd_q, sh_rd_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] bus_q, bus_d;
  logic [4:0]  rd_q, rd_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  logic        accept, load, ld_ovf;
  logic [31:0] ld_res;
  logic [4:0]  ld_rd, step;

  function automatic logic is_shift(input logic [3:0] f_op);
    return (f_op == 4'd8) || (f_op == 4'd9) || (f_op == 4'd10);
  endfunction

  // Returns {ovf, result}; shift ops only get here with a zero shift amount.
  function automatic logic [32:0] alu_eval(input logic [3:0] f_op,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic signed [31:0] sum, diff;
    logic ovf_add, ovf_sub, v;
    logic [31:0] res;
    sum     = a + b;
    diff    = a - b;
    ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
    ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);
    v       = 1'b0;
    case (f_op)
      4'd0:    begin res = sum;  v = ovf_add; end
      4'd1:    begin res = diff; v = ovf_sub; end
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = ~(a | b);
      4'd6:    res = {31'b0, diff[31] ^ ovf_sub};
`ifdef ALU_SLTU_EN
      4'd7:    res = {31'b0, $unsigned(a) < $unsigned(b)};
`endif
      4'd8, 4'd9, 4'd10: res = b;
      default: res = '0;
    endcase
    return {v, res};
  endfunction

  function automatic logic [31:0] shift_step(input logic [3:0] f_op,
                                             input logic [31:0] v,
                                             input logic [4:0] amt);
    logic signed [31:0] vs;
    vs = $signed(v);
    case (f_op)
      4'd8:    return v << amt;
      4'd9:    return v >> amt;
      default: return vs >>> amt;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    sh_val_d    = sh_val_q;
    sh_rem_d    = sh_rem_q;
    sh_op_d     = sh_op_q;
    sh_rd_d     = sh_rd_q;
    out_valid_d = out_valid_q;
    bus_d       = bus_q;
    rd_d        = rd_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    load        = 1'b0;
    ld_res      = '0;
    ld_rd       = '0;
    ld_ovf      = 1'b0;
    step        = (sh_rem_q < SPC) ? sh_rem_q : SPC;

    in_ready = !reset && !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;

    if (state_q == SHIFT) begin
      sh_val_d = shift_step(sh_op_q, sh_val_q, step);
      sh_rem_d = sh_rem_q - step;
      if (sh_rem_d == 5'd0) begin
        load    = 1'b1;
        ld_res  = sh_val_d;
        ld_rd   = sh_rd_q;
        state_d = IDLE;
      end
    end else if (accept) begin
      if (is_shift(op) && (shamt != 5'd0)) begin
        sh_val_d = busB;
        sh_rem_d = shamt;
        sh_op_d  = op;
        sh_rd_d  = rd;
        state_d  = SHIFT;
      end else begin
        load             = 1'b1;
        {ld_ovf, ld_res} = alu_eval(op, busA, busB);
        ld_rd            = rd;
      end
    end

    // Output register: a new load wins over a drain in the same edge.
    if (load) begin
      out_valid_d = 1'b1;
      bus_d       = ld_res;
      rd_d        = ld_rd;
      ovf_d       = ld_ovf;
      zero_d      = (ld_res == 32'd0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      bus_q       <= '0;
      rd_q        <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      bus_q       <= bus_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_val_q <= sh_val_d;
    sh_rem_q <= sh_rem_d;
    sh_op_q  <= sh_op_d;
    sh_rd_q  <= sh_rd_d;
  end

  assign out_valid = out_valid_q;
  assign busOut    = bus_q;
  assign out_rd    = rd_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
